// File: rtl/tc_pkg.sv
// Shared definitions for the timer/counter bus master: register map, FSM states, command record.
// IQ_* states exist only when TC_MASTER_IRQ_EN is defined.
package tc_pkg;

    localparam logic [7:0] TCCRA = 8'h24;
    localparam logic [7:0] TCCRB = 8'h25;
    localparam logic [7:0] TCNT  = 8'h26;
    localparam logic [7:0] OCRA  = 8'h27;
    localparam logic [7:0] OCRB  = 8'h28;
    localparam logic [7:0] TIFR  = 8'h15;
    localparam logic [7:0] TIMSK = 8'h6E;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CAP,
        RSP
`ifdef TC_MASTER_IRQ_EN
        ,
        IQ_RD,
        IQ_CAP,
        IQ_CLR
`endif
    } tc_mst_state_e;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } tc_cmd_t;

endpackage

// File: rtl/tc_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module tc_cmd_fifo import tc_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  tc_cmd_t din,
    input  logic    pop,
    output tc_cmd_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    tc_cmd_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tc_bus_master.sv
// Bus initiator for the tc register block: queued writes/reads plus optional TIFR interrupt service.
// Interrupt service is compiled in only when TC_MASTER_IRQ_EN is defined.
module tc_bus_master import tc_pkg::*; #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [7:0]  TIFR_ADDR = TIFR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       write,
    output logic       read,
    input  logic [7:0] rdata,
    input  logic       interrupt_request,
    output logic       irq_valid,
    output logic [7:0] irq_flags,
    output logic       busy
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    tc_mst_state_e state;
    tc_cmd_t       fifo_din;
    tc_cmd_t       fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [2:0]    lat_cnt;

    assign fifo_din  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

`ifdef TC_MASTER_IRQ_EN
    logic irq_q1;
    logic irq_q2;
    logic irq_pend;
    logic irq_edge;
    logic irq_take;

    // An edge seen in IDLE is taken at once so it beats a command queued in the same cycle.
    assign irq_edge = irq_q1 && !irq_q2;
    assign irq_take = (state == IDLE) && (irq_pend || irq_edge);
    assign fifo_pop = (state == IDLE) && !irq_take && !fifo_empty;
`else
    logic unused_irq;
    assign unused_irq = interrupt_request;
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign irq_valid  = 1'b0;
    assign irq_flags  = '0;
`endif

    tc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            addr      <= '0;
            wdata     <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
`ifdef TC_MASTER_IRQ_EN
            irq_q1    <= 1'b0;
            irq_q2    <= 1'b0;
            irq_pend  <= 1'b0;
            irq_valid <= 1'b0;
            irq_flags <= '0;
`endif
        end else begin
`ifdef TC_MASTER_IRQ_EN
            irq_q1 <= interrupt_request;
            irq_q2 <= irq_q1;
            if (irq_take)
                irq_pend <= 1'b0;
            else if (irq_edge)
                irq_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef TC_MASTER_IRQ_EN
                    if (irq_take) begin
                        addr    <= TIFR_ADDR;
                        read    <= 1'b1;
                        lat_cnt <= LAT_LOAD;
                        state   <= IQ_RD;
                    end else
`endif
                    if (fifo_pop) begin
                        addr  <= fifo_dout.addr;
                        wdata <= fifo_dout.wdata;
                        if (fifo_dout.write) begin
                            write <= 1'b1;
                            state <= WR;
                        end else begin
                            read    <= 1'b1;
                            lat_cnt <= LAT_LOAD;
                            state   <= RD;
                        end
                    end
                end
                WR: begin
                    write <= 1'b0;
                    state <= IDLE;
                end
                RD: begin
                    if (lat_cnt == 3'd0) begin
                        read  <= 1'b0;
                        state <= CAP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                CAP: begin
                    rsp_data  <= rdata;
                    rsp_addr  <= addr;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef TC_MASTER_IRQ_EN
                IQ_RD: begin
                    if (lat_cnt == 3'd0) begin
                        read  <= 1'b0;
                        state <= IQ_CAP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                IQ_CAP: begin
                    // Writing the flags back clears them in TIFR.
                    irq_flags <= rdata;
                    wdata     <= rdata;
                    write     <= 1'b1;
                    irq_valid <= 1'b1;
                    state     <= IQ_CLR;
                end
                IQ_CLR: begin
                    write     <= 1'b0;
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_bus_master.sv
// Directed self-checking bench for tc_bus_master (DEPTH=4, RD_LAT=1).
// Interrupt expectations follow TC_MASTER_IRQ_EN as compiled.
`timescale 1ns/1ps
module tb_tc_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_addr;
    logic [7:0] rsp_data;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic       read;
    logic [7:0] rdata;
    logic       interrupt_request;
    logic       irq_valid;
    logic [7:0] irq_flags;
    logic       busy;

    logic [7:0] tifr_val;
    logic       overlap_seen;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Register responder: TIFR returns tifr_val, every other address returns addr ^ 0x3F.
    always_comb rdata = (addr == 8'h15) ? tifr_val : (addr ^ 8'h3F);

    always @(negedge clk) if (read && write) overlap_seen = 1'b1;

    tc_bus_master #(.DEPTH(4), .RD_LAT(1), .TIFR_ADDR(8'h15)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_addr          (rsp_addr),
        .rsp_data          (rsp_data),
        .addr              (addr),
        .wdata             (wdata),
        .write             (write),
        .read              (read),
        .rdata             (rdata),
        .interrupt_request (interrupt_request),
        .irq_valid         (irq_valid),
        .irq_flags         (irq_flags),
        .busy              (busy)
    );

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
        int unsigned guard = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: cmd_ready=%b expected 1 within 100 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; interrupt_request = 1'b0; tifr_val = 8'h06; overlap_seen = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL rst_strobes: write=%b read=%b expected 0 0", write, read); end
        checks++; if (rsp_valid !== 1'b0 || rsp_addr !== 8'h00 || rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp: valid=%b addr=%h data=%h expected 0 00 00", rsp_valid, rsp_addr, rsp_data); end
        checks++; if (addr !== 8'h00 || wdata !== 8'h00) begin errors++; $display("FAIL rst_bus: addr=%h wdata=%h expected 00 00", addr, wdata); end
        checks++; if (irq_valid !== 1'b0 || irq_flags !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rst_misc: irq_valid=%b irq_flags=%h busy=%b expected 0 00 0", irq_valid, irq_flags, busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h25; cmd_wdata = 8'h03;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL wr_cycle1: write=%b expected 0", write); end
        @(negedge clk);
        checks++; if (write !== 1'b1 || read !== 1'b0) begin errors++; $display("FAIL wr_cycle2: write=%b read=%b expected 1 0", write, read); end
        checks++; if (addr !== 8'h25 || wdata !== 8'h03) begin errors++; $display("FAIL wr_bus: addr=%h wdata=%h expected 25 03", addr, wdata); end
        @(negedge clk);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL wr_single_pulse: write=%b expected 0", write); end
        repeat (4) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_read();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h27; cmd_wdata = 8'hAA;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL rd_cycle1: read=%b expected 0", read); end
        @(negedge clk);
        checks++; if (read !== 1'b1 || write !== 1'b0 || addr !== 8'h27) begin errors++; $display("FAIL rd_cycle2: read=%b write=%b addr=%h expected 1 0 27", read, write, addr); end
        @(negedge clk);
        checks++; if (read !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_cycle3: read=%b rsp_valid=%b expected 0 0", read, rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 8'h27 || rsp_data !== 8'h18) begin errors++; $display("FAIL rd_rsp: valid=%b addr=%h data=%h expected 1 27 18", rsp_valid, rsp_addr, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_hold: rsp_valid=%b expected 1", rsp_valid); end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_drop: rsp_valid=%b expected 0", rsp_valid); end
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_addr[$];
        logic [7:0] got_data[$];
        logic [7:0] a;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b0, 8'h24 + 8'(i), 8'h00);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: cmd_ready=%b expected 0", cmd_ready); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && got_addr.size() < 5; c++) begin
            if (rsp_valid) begin
                got_addr.push_back(rsp_addr);
                got_data.push_back(rsp_data);
            end
            @(negedge clk);
        end
        checks++; if (got_addr.size() != 5) begin errors++; $display("FAIL b2b_count: responses=%0d expected 5", got_addr.size()); end
        for (int i = 0; i < got_addr.size() && i < 5; i++) begin
            a = 8'h24 + 8'(i);
            checks++;
            if (got_addr[i] !== a || got_data[i] !== (a ^ 8'h3F)) begin
                errors++;
                $display("FAIL b2b_rsp%0d: addr=%h data=%h expected %h %h", i, got_addr[i], got_data[i], a, a ^ 8'h3F);
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drained: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_irq();
        int         pulses = 0;
        logic       seen_rd15 = 1'b0;
        logic       seen_wr = 1'b0;
        logic [7:0] wr_addr = '0;
        logic [7:0] wr_data = '0;
        logic       wr_with_pulse = 1'b0;
        tifr_val = 8'h06;
        interrupt_request = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (read && addr == 8'h15) seen_rd15 = 1'b1;
            if (write) begin seen_wr = 1'b1; wr_addr = addr; wr_data = wdata; end
            if (irq_valid) begin pulses++; wr_with_pulse = write; end
        end
`ifdef TC_MASTER_IRQ_EN
        checks++; if (seen_rd15 !== 1'b1) begin errors++; $display("FAIL irq_read_tifr: seen=%b expected 1", seen_rd15); end
        checks++; if (seen_wr !== 1'b1 || wr_addr !== 8'h15 || wr_data !== 8'h06) begin errors++; $display("FAIL irq_clear_write: seen=%b addr=%h wdata=%h expected 1 15 06", seen_wr, wr_addr, wr_data); end
        checks++; if (pulses != 1 || wr_with_pulse !== 1'b1) begin errors++; $display("FAIL irq_pulse: pulses=%0d with_write=%b expected 1 1", pulses, wr_with_pulse); end
        checks++; if (irq_flags !== 8'h06) begin errors++; $display("FAIL irq_flags: got %h expected 06", irq_flags); end
`else
        checks++; if (seen_rd15 !== 1'b0 || seen_wr !== 1'b0) begin errors++; $display("FAIL irq_disabled_bus: read15=%b write=%b expected 0 0", seen_rd15, seen_wr); end
        checks++; if (pulses != 0 || irq_flags !== 8'h00) begin errors++; $display("FAIL irq_disabled_out: pulses=%0d flags=%h expected 0 00", pulses, irq_flags); end
`endif
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL irq_idle_after: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
        interrupt_request = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_irq_priority();
        logic [8:0] ev[$];
        logic [8:0] exp_ev[$];
        logic [7:0] r_addr = '0;
        logic [7:0] r_data = '0;
        int         nrsp = 0;
`ifdef TC_MASTER_IRQ_EN
        exp_ev.push_back({1'b0, 8'h15});
        exp_ev.push_back({1'b1, 8'h15});
`endif
        exp_ev.push_back({1'b0, 8'h26});
        tifr_val = 8'h0C;
        rsp_ready = 1'b1;
        interrupt_request = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h26;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (read) ev.push_back({1'b0, addr});
            if (write) ev.push_back({1'b1, addr});
            if (rsp_valid) begin nrsp++; r_addr = rsp_addr; r_data = rsp_data; end
            @(negedge clk);
        end
        checks++; if (ev.size() != exp_ev.size()) begin errors++; $display("FAIL prio_events: count=%0d expected %0d", ev.size(), exp_ev.size()); end
        for (int i = 0; i < ev.size() && i < exp_ev.size(); i++) begin
            checks++;
            if (ev[i] !== exp_ev[i]) begin errors++; $display("FAIL prio_event%0d: got %h expected %h", i, ev[i], exp_ev[i]); end
        end
        checks++; if (nrsp != 1 || r_addr !== 8'h26 || r_data !== 8'h19) begin errors++; $display("FAIL prio_rsp: n=%0d addr=%h data=%h expected 1 26 19", nrsp, r_addr, r_data); end
        interrupt_request = 1'b0;
        rsp_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int unsigned guard = 0;
        int          wr_seen = 0;
        rsp_ready = 1'b0;
        push(1'b0, 8'h24, 8'h00);
        push(1'b1, 8'h28, 8'h5A);
        while (!read && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (read !== 1'b1) begin errors++; $display("FAIL rstmid_reach_rd: read=%b expected 1", read); end
        rst = 1'b1;
        #1;
        checks++; if (read !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: read=%b busy=%b expected 0 0", read, busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (write || read) wr_seen++;
        end
        checks++; if (wr_seen != 0) begin errors++; $display("FAIL rstmid_flushed: strobes=%0d expected 0", wr_seen); end
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: rsp_valid=%b cmd_ready=%b busy=%b expected 0 1 0", rsp_valid, cmd_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_irq();
        test_irq_priority();
        test_reset_mid_read();
        checks++;
        if (overlap_seen !== 1'b0) begin errors++; $display("FAIL bus_overlap: read and write both high seen=%b expected 0", overlap_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
